// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by both the control-unit decoder and the program loader.
package mips_pkg;

   typedef enum logic [3:0] {
      CMD_ADD  = 4'd0,
      CMD_SUB  = 4'd1,
      CMD_AND  = 4'd2,
      CMD_OR   = 4'd3,
      CMD_SLT  = 4'd4,
      CMD_ADDI = 4'd5,
      CMD_LW   = 4'd6,
      CMD_SW   = 4'd7
   } cmd_op_e;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
   localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
   localparam logic [5:0] OPCODE_LW    = 6'b100011;
   localparam logic [5:0] OPCODE_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_LSB    = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } loader_state_e;

   // Shamt field stays zero for every R-type op this loader supports.
   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return (32'(OPCODE_RTYPE) << OPCODE_LSB) | (32'(rs) << RS_LSB) |
             (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) | (32'(funct) << FUNCT_LSB);
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opcode, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return (32'(opcode) << OPCODE_LSB) | (32'(rs) << RS_LSB) |
             (32'(rt) << RT_LSB) | (32'(imm) << IMM_LSB);
   endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational encoder: symbolic command fields to a 32-bit MIPS instruction word.
module mips_instr_encoder
   import mips_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = 32'd0;
      illegal = 1'b0;
      case (op)
         CMD_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
         CMD_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
         CMD_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
         CMD_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
         CMD_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
         CMD_ADDI: word = i_word(OPCODE_ADDI, rs, rt, imm);
         CMD_LW:   word = i_word(OPCODE_LW, rs, rt, imm);
         CMD_SW:   word = i_word(OPCODE_SW, rs, rt, imm);
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_program_loader.sv
// Accepts symbolic commands over valid/ready and writes the encoded words sequentially into instruction memory.
module mips_program_loader
   import mips_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [3:0]        CMD_OP,
   input  logic [4:0]        CMD_RS,
   input  logic [4:0]        CMD_RT,
   input  logic [4:0]        CMD_RD,
   input  logic [15:0]       CMD_IMM,
   input  logic              CMD_LAST,
   input  logic              RESTART,
   output logic              IMEM_WE,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic [31:0]       IMEM_WDATA,
   output logic [ADDR_W:0]   COUNT,
   output logic              FULL,
   output logic              DONE,
   output logic              ERR
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   loader_state_e     state_q, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic              err_q;
   logic [31:0]       word_p1;
   logic              last_p1;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              hs;

   mips_instr_encoder u_encoder (
      .op      (CMD_OP),
      .rs      (CMD_RS),
      .rt      (CMD_RT),
      .rd      (CMD_RD),
      .imm     (CMD_IMM),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign FULL       = (count_q == DEPTH_CNT);
   assign CMD_READY  = (state_q == ST_IDLE) && !FULL;
   assign hs         = CMD_VALID && CMD_READY && !RESTART;
   // A RESTART during WRITE aborts the pending store in the same cycle.
   assign IMEM_WE    = (state_q == ST_WRITE) && !RESTART;
   assign IMEM_ADDR  = addr_q;
   assign IMEM_WDATA = word_p1;
   assign COUNT      = count_q;
   assign DONE       = (state_q == ST_DONE);
   assign ERR        = err_q;

   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (!enc_illegal)  state_n = ST_WRITE;
               else if (CMD_LAST) state_n = ST_DONE;
            end
         end
         ST_WRITE: state_n = last_p1 ? ST_DONE : ST_IDLE;
         ST_DONE:  state_n = ST_DONE;
         default:  state_n = ST_IDLE;
      endcase
      if (RESTART) state_n = ST_IDLE;
   end

   // Stage p1: command latched at the handshake, written to memory the following cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         word_p1 <= 32'd0;
         last_p1 <= 1'b0;
      end else begin
         state_q <= state_n;
         if (RESTART) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            if (hs && enc_illegal) err_q <= 1'b1;
            if (hs && !enc_illegal) begin
               word_p1 <= enc_word;
               last_p1 <= CMD_LAST;
            end
            if (IMEM_WE) begin
               addr_q  <= addr_q + 1'b1;
               count_q <= count_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Encoder counterpart to the MIPS control unit's instruction decoder.
- Accepts symbolic instruction commands (operation, register fields, immediate) over a valid/ready handshake.
- Encodes each command into a 32-bit MIPS word and writes it sequentially into instruction memory.
- Sits between the host/test harness and instruction memory; it loads the program that the datapath's decoder later consumes.

Parameters:
- DEPTH, 64, instruction memory depth in words; must be a power of two.
- ADDR_W, 6, word-address width; equals log2(DEPTH).

Ports:
- CLK  input  1  single system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  loader can accept a command this cycle.
- CMD_OP  input  4  operation: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 lw, 7 sw; 8-15 illegal.
- CMD_RS  input  5  source register rs.
- CMD_RT  input  5  register rt (R-type second source; I-type destination or store source).
- CMD_RD  input  5  destination register rd (R-type only; ignored for I-type).
- CMD_IMM  input  16  immediate or offset (I-type only; ignored for R-type).
- CMD_LAST  input  1  marks the final command of a program.
- RESTART  input  1  single-cycle pulse: clear address, count and flags, return to IDLE.
- IMEM_WE  output  1  instruction memory write enable.
- IMEM_ADDR  output  ADDR_W  word address of the current write.
- IMEM_WDATA  output  32  encoded instruction word.
- COUNT  output  ADDR_W+1  number of words written so far.
- FULL  output  1  COUNT == DEPTH.
- DONE  output  1  last command has been written.
- ERR  output  1  sticky: an illegal CMD_OP was received.

Behaviour:
- Reset values (RST high, asynchronous): state IDLE, address 0, COUNT 0, IMEM_WE 0, IMEM_WDATA 0, FULL 0, DONE 0, ERR 0.
  - CMD_READY is 1 when not in reset.
  - No handshake is honoured while RST is high.
- CMD_READY = (state == IDLE) and not FULL.
- A handshake occurs on a rising edge where CMD_VALID and CMD_READY are both 1.
- FSM states:
  - IDLE: on handshake with a legal op, latch the encoded word and CMD_LAST, then go to WRITE.
  - IDLE, illegal op: set ERR; the command is consumed and nothing is written. If CMD_LAST is also set, go to DONE; otherwise stay in IDLE.
  - WRITE: IMEM_WE = 1 for exactly one cycle, with IMEM_ADDR = current address and IMEM_WDATA = the latched word. At the end of the cycle, address and COUNT increment. Next state is DONE if the latched LAST is set, otherwise IDLE.
  - DONE: DONE = 1 and CMD_READY = 0; the FSM holds until RESTART.
- Latency and throughput:
  - Handshake at edge k causes IMEM_WE to be high during cycle k+1.
  - Maximum throughput is one instruction per 2 cycles.
- Encoding:
  - R-type word: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type word: {opcode, rs, rt, imm}.
  - opcode values: addi 001000, lw 100011, sw 101011.
  - The immediate is passed through unmodified; sign extension is the datapath's job.
- Full:
  - After the DEPTH-th write, FULL = 1 and CMD_READY = 0.
  - The address wraps to 0 internally, but no further write occurs until RESTART.
  - If the DEPTH-th command carries LAST, the FSM goes to DONE and FULL is also set.
- RESTART:
  - Synchronous and highest priority after RST, from any state.
  - In WRITE, the pending write is aborted: IMEM_WE is forced to 0 that cycle.
  - A handshake in the same cycle as RESTART is ignored.
- ERR:
  - Cleared only by RST or RESTART.
  - Does not block further commands.
- Reset mid-WRITE: IMEM_WE drops immediately (asynchronously); the partial write is discarded.

Decomposition:
- Shared package mips_pkg holds:
  - CMD_OP encodings.
  - OPCODE constants (R-type 000000, addi, lw, sw).
  - FUNCT constants (add, sub, and, or, slt).
  - Field-position constants.
- The control unit and this loader both draw their constants from mips_pkg.
- One combinational sub-module, mips_instr_encoder, takes (op, rs, rt, rd, imm) and returns (word, illegal).
- The loader owns the FSM, address/count registers and flags.

Test Plan:
- Reset, then add rs=1 rt=2 rd=3 → one cycle after the handshake: IMEM_WE=1, ADDR 0, WDATA 0x00221820; COUNT=1; CMD_READY returns to 1.
- Back-to-back stream: addi rs=0 rt=1 imm=5; lw rs=5 rt=4 imm=8; sw rs=0 rt=4 imm=0xFFFC with LAST → words 0x20010005, 0x8CA40008, 0xAC04FFFC at addresses 0, 1, 2; DONE=1; CMD_READY=0; COUNT=3.
- CMD_OP=9 (illegal) followed by a legal sub rs=1 rt=2 rd=3 → ERR=1 and sticky; no write for op 9; sub written at ADDR 0 with WDATA 0x00221822.
- DEPTH=64: write 64 commands with no LAST → FULL=1 after the 64th write, CMD_READY=0, a 65th VALID is not accepted. RESTART then gives COUNT=0, FULL=0, next write at ADDR 0.
- RST asserted during a WRITE cycle → IMEM_WE drops the same cycle; all outputs at their reset values.
- RESTART pulsed in WRITE with CMD_VALID high → no write, no handshake that cycle; state IDLE and COUNT=0 on the next cycle.
